triple_voter: RTL and testbench
===============================

// Module: triple_voter
// PURPOSE
//  Bit-level triple-modular-redundancy (TMR) majority voter with fault bookkeeping.
//  Three redundant copies of one signal (a, b, c) are voted to a single output y.
//  y is combinational; the block also records which copy disagrees with the majority.
//  Sits between the three redundant logic lanes and the downstream consumer.
// PARAMETERS
//  CNT_W   16   width of each per-lane disagreement counter (saturating)
// PORTS
//  clk        in   1      system clock, rising-edge active
//  rst_n      in   1      asynchronous, active-low reset
//  a          in   1      redundant copy 0
//  b          in   1      redundant copy 1
//  c          in   1      redundant copy 2
//  y          out  1      majority vote: (a&b)|(b&c)|(a&c)
//  clr        in   1      synchronous clear of sticky flags and counters (tie 0 if unused)
//  y_q        out  1      y registered one cycle
//  mismatch   out  1      registered: lanes disagreed on the previous clock edge
//  fault_abc  out  3      sticky per-lane fault flags {c,b,a}
//  err_cnt_a  out  CNT_W  count of cycles where a != y
//  err_cnt_b  out  CNT_W  count of cycles where b != y
//  err_cnt_c  out  CNT_W  count of cycles where c != y
// BEHAVIOUR
//  - Ports clk, rst_n, a, b, c, y come first in exactly this order (positional instantiation).
//  - One clock; reset asynchronous, active-low. All flops clear immediately on rst_n=0.
//  - y: purely combinational majority, zero latency, NOT gated by reset; y=maj(a,b,c) at all times.
//  - Reset values: y_q=0, mismatch=0, fault_abc=3'b000, err_cnt_*=0.
//  - Per rising edge (rst_n=1):
//     y_q <= maj(a,b,c)
//     mismatch <= !(a==b && b==c)
//     for lane x in {a,b,c}: if x != maj -> fault_abc[x] <= 1, err_cnt_x <= err_cnt_x+1
//  - At most one lane can disagree with the majority in any cycle.
//  - Counters saturate at 2**CNT_W-1; never wrap.
//  - clr=1 at an edge: fault_abc and err_cnt_* go to 0; clr wins over simultaneous increment/set.
//    clr does not affect y, y_q or mismatch.
//  - Reset deassertion mid-stream: first edge after release samples inputs normally.
//  - Inputs are sampled synchronous to clk; no internal synchronisers.
// STRUCTURE
//  - Shared package tmr_pkg: function maj3(a,b,c) and default CNT_W constant.
//  - One sub-module natural: tmr_err_counter (saturating counter, inc and clr),
//    instantiated three times, one per lane.
//  - Top holds majority logic, y_q/mismatch flops and sticky flags.
// TESTING
//  1) Reset held 10ns then released; a=b=c=0 -> y=0, y_q=0, mismatch=0, all counters 0.
//  2) Sweep abc 000..111 one per clock (10ns period) -> y = 0,0,0,1,0,1,1,1 immediately
//     after each change; y_q matches y one edge later.
//  3) a=1,b=0,c=0 for 5 edges -> y=0, fault_abc=3'b001, err_cnt_a=5, others 0, mismatch=1.
//  4) Apply clr=1 for one edge while c alone disagrees -> fault_abc=0, err_cnt_c=0 after edge.
//  5) CNT_W=2, b disagrees for 6 edges -> err_cnt_b stops at 3.
//  6) Assert rst_n=0 mid-run with nonzero counters -> all registered outputs 0 without a clock edge;
//     y still tracks majority of a,b,c.

Source files
------------

// File: rtl/tmr_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tmr_pkg
// Brief    : Shared majority function and default counter width for TMR voting
// Revision : 1.0 - initial release
// ============================================================================
package tmr_pkg;

  localparam int c_CNT_W_DEFAULT = 16;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (b & c) | (a & c);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tmr_err_counter.sv
`default_nettype none
// ============================================================================
// Module   : tmr_err_counter
// Brief    : Saturating per-lane disagreement counter with synchronous clear
// Revision : 1.0 - initial release
// ============================================================================
module tmr_err_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] c_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_count;
  logic             w_sat;

  assign w_sat = (r_count == c_MAX);

  // Clear takes priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && !w_sat) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/triple_voter.sv
`default_nettype none
// ============================================================================
// Module   : triple_voter
// Brief    : Bit-level TMR majority voter with sticky lane-fault flags and
//            saturating per-lane disagreement counters
// Revision : 1.0 - initial release
// ============================================================================
module triple_voter
  import tmr_pkg::*;
#(
  parameter int CNT_W = c_CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             y,
  input  logic             clr,
  output logic             y_q,
  output logic             mismatch,
  output logic [2:0]       fault_abc,
  output logic [CNT_W-1:0] err_cnt_a,
  output logic [CNT_W-1:0] err_cnt_b,
  output logic [CNT_W-1:0] err_cnt_c
);

  logic             w_y;
  logic [2:0]       w_lanes;
  logic [2:0]       w_lane_err;
  logic [CNT_W-1:0] w_cnt [3];

  logic             r_y_q;
  logic             r_mismatch;
  logic [2:0]       r_fault;

  // The vote stays live during reset so downstream logic never loses the signal.
  assign w_y        = maj3(a, b, c);
  assign w_lanes    = {c, b, a};
  assign w_lane_err = w_lanes ^ {3{w_y}};
  assign y          = w_y;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_q      <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      r_y_q      <= w_y;
      r_mismatch <= !((a == b) && (b == c));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fault <= 3'b000;
    end else if (clr) begin
      r_fault <= 3'b000;
    end else begin
      r_fault <= r_fault | w_lane_err;
    end
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_lane_cnt
    tmr_err_counter #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (w_lane_err[gi]),
      .clr   (clr),
      .count (w_cnt[gi])
    );
  end

  assign y_q       = r_y_q;
  assign mismatch  = r_mismatch;
  assign fault_abc = r_fault;
  assign err_cnt_a = w_cnt[0];
  assign err_cnt_b = w_cnt[1];
  assign err_cnt_c = w_cnt[2];

endmodule
`default_nettype wire

// File: tb/tb_triple_voter.sv
`default_nettype none
// ============================================================================
// Module   : tb_triple_voter
// Brief    : Directed bench for triple_voter (16-bit and 2-bit counter builds)
// Revision : 1.0 - initial release
// ============================================================================
module tb_triple_voter;

  logic        clk;
  logic        rst_n;
  logic        a, b, c, clr;
  logic        y, y_q, mismatch;
  logic [2:0]  fault_abc;
  logic [15:0] err_cnt_a, err_cnt_b, err_cnt_c;
  logic        y2, y_q2, mismatch2;
  logic [2:0]  fault_abc2;
  logic [1:0]  err_cnt_a2, err_cnt_b2, err_cnt_c2;

  int checks   = 0;
  int failures = 0;

  triple_voter #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .y(y), .clr(clr),
    .y_q(y_q), .mismatch(mismatch), .fault_abc(fault_abc),
    .err_cnt_a(err_cnt_a), .err_cnt_b(err_cnt_b), .err_cnt_c(err_cnt_c)
  );

  triple_voter #(.CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c), .y(y2), .clr(clr),
    .y_q(y_q2), .mismatch(mismatch2), .fault_abc(fault_abc2),
    .err_cnt_a(err_cnt_a2), .err_cnt_b(err_cnt_b2), .err_cnt_c(err_cnt_c2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive new inputs on the falling edge so they settle well before the next rising edge.
  task automatic drive(input logic [2:0] abc, input logic clr_v);
    @(negedge clk);
    {a, b, c} = abc;
    clr = clr_v;
  endtask

  task automatic edge_settle();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp_y_tbl;
  logic [7:0] exp_mm_tbl;

  initial begin
    exp_y_tbl  = 8'b1110_1000;
    exp_mm_tbl = 8'b0111_1110;
    rst_n = 1'b0;
    {a, b, c} = 3'b000;
    clr = 1'b0;

    // 1) reset state
    #9;
    check("reset_y",        32'(y),         32'd0);
    check("reset_y_q",      32'(y_q),       32'd0);
    check("reset_mismatch", 32'(mismatch),  32'd0);
    check("reset_fault",    32'(fault_abc), 32'd0);
    check("reset_cnt_a",    32'(err_cnt_a), 32'd0);
    check("reset_cnt_b",    32'(err_cnt_b), 32'd0);
    check("reset_cnt_c",    32'(err_cnt_c), 32'd0);
    #1 rst_n = 1'b1;
    edge_settle();
    check("post_rst_y_q",     32'(y_q),      32'd0);
    check("post_rst_mismatch",32'(mismatch), 32'd0);
    check("post_rst_cnt_a",   32'(err_cnt_a),32'd0);

    // 2) sweep abc 000..111
    for (int v = 0; v < 8; v++) begin
      drive(3'(v), 1'b0);
      #1;
      check($sformatf("sweep_y_%0d", v), 32'(y), 32'(exp_y_tbl[v]));
      edge_settle();
      check($sformatf("sweep_y_q_%0d", v), 32'(y_q), 32'(exp_y_tbl[v]));
      check($sformatf("sweep_mm_%0d", v), 32'(mismatch), 32'(exp_mm_tbl[v]));
    end
    // 001,010,100 make a/b/c outliers once each; 011,101,110 likewise
    check("sweep_fault", 32'(fault_abc), 32'b111);
    check("sweep_cnt_a", 32'(err_cnt_a), 32'd2);
    check("sweep_cnt_c", 32'(err_cnt_c), 32'd2);

    // 3) lane a alone disagrees for 5 edges
    drive(3'b000, 1'b1);
    edge_settle();
    check("clr_fault", 32'(fault_abc), 32'd0);
    check("clr_cnt_b", 32'(err_cnt_b), 32'd0);
    drive(3'b100, 1'b0);
    for (int i = 0; i < 5; i++) edge_settle();
    check("a_out_y",        32'(y),         32'd0);
    check("a_out_y_q",      32'(y_q),       32'd0);
    check("a_out_fault",    32'(fault_abc), 32'b001);
    check("a_out_cnt_a",    32'(err_cnt_a), 32'd5);
    check("a_out_cnt_b",    32'(err_cnt_b), 32'd0);
    check("a_out_cnt_c",    32'(err_cnt_c), 32'd0);
    check("a_out_mismatch", 32'(mismatch),  32'd1);

    // 4) clr wins over c disagreeing on the same edge
    drive(3'b001, 1'b1);
    edge_settle();
    check("clr_win_fault",    32'(fault_abc), 32'd0);
    check("clr_win_cnt_c",    32'(err_cnt_c), 32'd0);
    check("clr_win_cnt_a",    32'(err_cnt_a), 32'd0);
    check("clr_win_mismatch", 32'(mismatch),  32'd1);
    drive(3'b001, 1'b0);
    edge_settle();
    check("c_out_fault", 32'(fault_abc), 32'b100);
    check("c_out_cnt_c", 32'(err_cnt_c), 32'd1);

    // 5) b disagrees for 6 edges: 2-bit counter saturates at 3
    drive(3'b000, 1'b1);
    edge_settle();
    drive(3'b101, 1'b0);
    for (int i = 0; i < 3; i++) edge_settle();
    check("sat_cnt_b2_at3", 32'(err_cnt_b2), 32'd3);
    for (int i = 0; i < 3; i++) edge_settle();
    check("sat_cnt_b2",  32'(err_cnt_b2), 32'd3);
    check("sat_cnt_b16", 32'(err_cnt_b),  32'd6);
    check("sat_fault2",  32'(fault_abc2), 32'b010);
    check("sat_y",       32'(y),          32'd1);

    // 6) asynchronous reset mid-run with nonzero state
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    {a, b, c} = 3'b110;
    #1;
    check("arst_y_q",      32'(y_q),        32'd0);
    check("arst_mismatch", 32'(mismatch),   32'd0);
    check("arst_fault",    32'(fault_abc),  32'd0);
    check("arst_cnt_b",    32'(err_cnt_b),  32'd0);
    check("arst_cnt_b2",   32'(err_cnt_b2), 32'd0);
    check("arst_y_live1",  32'(y),          32'd1);
    {a, b, c} = 3'b010;
    #1;
    check("arst_y_live0",  32'(y),          32'd0);
    edge_settle();
    check("arst_hold_y_q", 32'(y_q),        32'd0);

    drive(3'b111, 1'b0);
    rst_n = 1'b1;
    edge_settle();
    check("release_y_q",      32'(y_q),       32'd1);
    check("release_mismatch", 32'(mismatch),  32'd0);
    check("release_fault",    32'(fault_abc), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
